jk_cmd_sequencer: RTL and testbench

JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

---
 rtl/jk_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | jk_cmd_sequencer                                                         |
// | Expands hold/reset/set/toggle commands into spaced J/K pulse trains and  |
// | checks the downstream Q against the predicted final value.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jk_cmd_sequencer #(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_rep,
  output logic       J,
  output logic       K,
  input  logic       q_fb,
  output logic       done,
  output logic       err,
  input  logic       err_clr,
  output logic [7:0] err_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  localparam bit       C_HAS_GAP  = (GAP > 0);
  localparam logic [3:0] C_GAP_LAST = 4'(GAP > 0 ? GAP - 1 : 0);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [4:0] rem_q, rem_d;
  logic [3:0] gap_q, gap_d;
  logic       expq_q, expq_d;
  logic       j_q, j_d;
  logic       k_q, k_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mismatch;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    expq_d   = expq_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    mismatch = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rem_d   = {1'b0, cmd_rep} + 5'd1;
          state_d = S_DRIVE;
          // Toggle flips Q once per pulse: odd pulse count (even rep) inverts.
          case (cmd_op)
            2'b00:   expq_d = q_fb;
            2'b01:   expq_d = 1'b0;
            2'b10:   expq_d = 1'b1;
            default: expq_d = q_fb ^ ~cmd_rep[0];
          endcase
        end
      end
      S_DRIVE: begin
        rem_d = rem_q - 5'd1;
        if (rem_q == 5'd1) begin
          state_d = S_CHECK;
        end else if (C_HAS_GAP) begin
          state_d = S_GAP;
          gap_d   = C_GAP_LAST;
        end else begin
          state_d = S_DRIVE;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = S_DRIVE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_CHECK: begin
        mismatch = (q_fb != expq_q);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A mismatch wins over a simultaneous clear and restarts the count at one.
    if (mismatch) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = 8'd1;
      end else if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (err_clr) begin
      err_d = 1'b0;
      cnt_d = 8'd0;
    end

    j_d = (state_d == S_DRIVE) & op_d[1];
    k_d = (state_d == S_DRIVE) & op_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      rem_q   <= 5'd0;
      gap_q   <= 4'd0;
      expq_q  <= 1'b0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
      expq_q  <= expq_d;
      j_q     <= j_d;
      k_q     <= k_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_CHECK);
  assign J         = j_q;
  assign K         = k_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for jk_cmd_sequencer: instance 0 has GAP=0, instance 1 has GAP=1,
// each driving a behavioural JK flop whose Q can be forced stuck at 0.
module tb_jk_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n[2], cmd_valid[2], cmd_ready[2], J[2], K[2], q_fb[2];
  logic       done[2], err[2], err_clr[2], busy[2];
  logic [1:0] cmd_op[2];
  logic [3:0] cmd_rep[2];
  logic [7:0] err_cnt[2];
  logic       q_dn[2], stuck[2], q_ld[2], q_ld_v[2];

  jk_cmd_sequencer #(.GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_rep(cmd_rep[0]), .J(J[0]), .K(K[0]), .q_fb(q_fb[0]),
    .done(done[0]), .err(err[0]), .err_clr(err_clr[0]), .err_cnt(err_cnt[0]), .busy(busy[0])
  );

  jk_cmd_sequencer #(.GAP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_rep(cmd_rep[1]), .J(J[1]), .K(K[1]), .q_fb(q_fb[1]),
    .done(done[1]), .err(err[1]), .err_clr(err_clr[1]), .err_cnt(err_cnt[1]), .busy(busy[1])
  );

  assign q_fb[0] = stuck[0] ? 1'b0 : q_dn[0];
  assign q_fb[1] = stuck[1] ? 1'b0 : q_dn[1];

  // Downstream JK storage element.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (q_ld[d]) q_dn[d] <= q_ld_v[d];
      else begin
        case ({J[d], K[d]})
          2'b01:   q_dn[d] <= 1'b0;
          2'b10:   q_dn[d] <= 1'b1;
          2'b11:   q_dn[d] <= ~q_dn[d];
          default: q_dn[d] <= q_dn[d];
        endcase
      end
    end
  end

  int   n_cmp = 0;
  int   n_mis = 0;
  logic m_err[2];
  int   m_cnt[2];

  function automatic void chk(input int d, input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", d, nm, act, exp, $time);
    end
  endfunction

  task automatic set_q(input int d, input logic v);
    q_ld[d] = 1'b1;
    q_ld_v[d] = v;
    @(negedge clk);
    q_ld[d] = 1'b0;
  endtask

  task automatic do_clr(input int d);
    err_clr[d] = 1'b1;
    @(negedge clk);
    err_clr[d] = 1'b0;
    m_err[d] = 1'b0;
    m_cnt[d] = 0;
    chk(d, "err_after_clr", err[d], 0);
    chk(d, "cnt_after_clr", err_cnt[d], 0);
  endtask

  // Starts just after a negedge with the DUT idle; ends just after the
  // negedge of the IDLE cycle that follows CHECK.
  task automatic run_cmd(input int d, input logic [1:0] op, input logic [3:0] rep,
                         input logic stk, input int lat, input logic mis,
                         input logic keep, input logic clr_chk);
    int gp;
    gp = (d == 1) ? 1 : 0;
    stuck[d] = stk;
    chk(d, "ready_idle", cmd_ready[d], 1);
    cmd_valid[d] = 1'b1;
    cmd_op[d]    = op;
    cmd_rep[d]   = rep;
    for (int k = 1; k <= lat; k++) begin
      logic drv;
      @(negedge clk);
      cmd_valid[d] = keep ? 1'b1 : 1'($urandom_range(0, 1));
      cmd_op[d]    = 2'($urandom);
      cmd_rep[d]   = 4'($urandom);
      drv = (k < lat) && (((k - 1) % (gp + 1)) == 0);
      chk(d, "J", J[d], drv & op[1]);
      chk(d, "K", K[d], drv & op[0]);
      chk(d, "done", done[d], (k == lat) ? 1 : 0);
      chk(d, "busy", busy[d], 1);
      if (k == lat && clr_chk) err_clr[d] = 1'b1;
    end
    @(negedge clk);
    err_clr[d]   = 1'b0;
    cmd_valid[d] = keep;
    if (mis) begin
      m_err[d] = 1'b1;
      m_cnt[d] = clr_chk ? 1 : ((m_cnt[d] == 255) ? 255 : m_cnt[d] + 1);
    end else if (clr_chk) begin
      m_err[d] = 1'b0;
      m_cnt[d] = 0;
    end
    chk(d, "err", err[d], m_err[d]);
    chk(d, "err_cnt", err_cnt[d], m_cnt[d]);
    chk(d, "done_after", done[d], 0);
    chk(d, "busy_after", busy[d], 0);
    stuck[d] = 1'b0;
  endtask

  typedef struct {
    int         d;
    logic [1:0] op;
    logic [3:0] rep;
    logic       qi;
    logic       stk;
    int         lat;
    logic       mis;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{d: 1, op: 2'b10, rep: 4'd0, qi: 1'b0, stk: 1'b0, lat: 2,  mis: 1'b0};
    tbl[1] = '{d: 1, op: 2'b11, rep: 4'd2, qi: 1'b0, stk: 1'b0, lat: 6,  mis: 1'b0};
    tbl[2] = '{d: 1, op: 2'b01, rep: 4'd3, qi: 1'b1, stk: 1'b0, lat: 8,  mis: 1'b0};
    tbl[3] = '{d: 1, op: 2'b00, rep: 4'd1, qi: 1'b1, stk: 1'b0, lat: 4,  mis: 1'b0};
    tbl[4] = '{d: 0, op: 2'b11, rep: 4'd3, qi: 1'b0, stk: 1'b0, lat: 5,  mis: 1'b0};
    tbl[5] = '{d: 0, op: 2'b10, rep: 4'd7, qi: 1'b0, stk: 1'b1, lat: 9,  mis: 1'b1};
    tbl[6] = '{d: 1, op: 2'b10, rep: 4'd0, qi: 1'b0, stk: 1'b1, lat: 2,  mis: 1'b1};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; cmd_valid[d] = 1'b0; cmd_op[d] = 2'b00; cmd_rep[d] = 4'd0;
      err_clr[d] = 1'b0; stuck[d] = 1'b0; q_ld[d] = 1'b0; q_ld_v[d] = 1'b0;
      m_err[d] = 1'b0; m_cnt[d] = 0;
    end

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_J", J[d], 0);
      chk(d, "rst_K", K[d], 0);
      chk(d, "rst_done", done[d], 0);
      chk(d, "rst_err", err[d], 0);
      chk(d, "rst_cnt", err_cnt[d], 0);
      chk(d, "rst_busy", busy[d], 0);
      chk(d, "rst_ready", cmd_ready[d], 1);
      rst_n[d] = 1'b1;
    end
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      set_q(tbl[i].d, tbl[i].qi);
      run_cmd(tbl[i].d, tbl[i].op, tbl[i].rep, tbl[i].stk, tbl[i].lat, tbl[i].mis, 1'b0, 1'b0);
    end
    do_clr(1);
    do_clr(0);

    // err_cnt saturation, then mismatch racing a clear
    for (int i = 0; i < 256; i++) run_cmd(0, 2'b10, 4'd0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
    chk(0, "cnt_saturated", err_cnt[0], 255);
    run_cmd(0, 2'b10, 4'd0, 1'b1, 2, 1'b1, 1'b0, 1'b1);
    do_clr(0);

    // Asynchronous reset during GAP of a rep=5 toggle
    set_q(1, 1'b0);
    cmd_valid[1] = 1'b1; cmd_op[1] = 2'b11; cmd_rep[1] = 4'd5;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    chk(1, "mid_J_drive", J[1], 1);
    chk(1, "mid_K_drive", K[1], 1);
    @(negedge clk);
    chk(1, "mid_busy_gap", busy[1], 1);
    #2 rst_n[1] = 1'b0;
    #1;
    chk(1, "async_J", J[1], 0);
    chk(1, "async_K", K[1], 0);
    chk(1, "async_busy", busy[1], 0);
    chk(1, "async_ready", cmd_ready[1], 1);
    m_err[1] = 1'b0; m_cnt[1] = 0;
    cmd_valid[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(1, "rst_hold_done", done[1], 0);
      chk(1, "rst_hold_busy", busy[1], 0);
    end
    cmd_valid[1] = 1'b0;
    rst_n[1] = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk(1, "no_replay_done", done[1], 0);
      chk(1, "no_replay_busy", busy[1], 0);
    end
    set_q(1, 1'b1);
    run_cmd(1, 2'b01, 4'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    // GAP=0 hold rep=15 with valid held, back-to-back second command
    set_q(0, 1'($urandom_range(0, 1)));
    run_cmd(0, 2'b00, 4'd15, 1'b0, 17, 1'b0, 1'b1, 1'b0);
    run_cmd(0, 2'b10, 4'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0);

    // Randomized commands against a rule-level prediction
    for (int i = 0; i < 60; i++) begin
      int         d, gp, lat;
      logic [1:0] op;
      logic [3:0] rep;
      logic       qi, stk, qf;
      d   = $urandom_range(0, 1);
      gp  = (d == 1) ? 1 : 0;
      op  = 2'($urandom);
      rep = 4'($urandom);
      qi  = 1'($urandom_range(0, 1));
      stk = ($urandom_range(0, 5) == 0);
      qf  = stk ? 1'b0 : qi;
      for (int p = 0; p <= int'(rep); p++) begin
        if (op == 2'b01) qf = 1'b0;
        else if (op == 2'b10) qf = 1'b1;
        else if (op == 2'b11) qf = ~qf;
      end
      lat = (int'(rep) + 1) + int'(rep) * gp + 1;
      set_q(d, qi);
      run_cmd(d, op, rep, stk, lat, stk & qf, 1'b0, 1'b0);
      if ($urandom_range(0, 7) == 0) do_clr(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
